// File: rtl/i8088_bus_master.sv
// 8088-style multiplexed bus cycle generator: T1-T4 sequencing with READY wait states.
// Optional macro BUS_TIMEOUT_EN adds a wait-state limit that aborts the cycle with rsp_err.
module i8088_bus_master #(
  parameter int unsigned ADDR_W = 20
`ifdef BUS_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 16
`endif
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_io,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [7:0]        req_wdata,
  output logic              rsp_valid,
  output logic [7:0]        rsp_rdata,
  output logic              rsp_err,
  output logic              ALE,
  output logic              RD,
  output logic              WR,
  output logic              IOM,
  output logic [11:0]       A_hi,
  output logic [7:0]        AD_out,
  output logic              AD_oe,
  input  logic [7:0]        AD_in,
  input  logic              READY
);

  typedef enum logic [2:0] {S_TI, S_T1, S_T2, S_T3, S_TW, S_T4} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_write;
  logic                r_io;
  logic [ADDR_W-1:0]   r_addr;
  logic [7:0]          r_wdata;

  logic                r_req_ready;
  logic                r_ale;
  logic                r_rd;
  logic                r_wr;
  logic                r_iom;
  logic [11:0]         r_a_hi;
  logic [7:0]          r_ad_out;
  logic                r_ad_oe;
  logic                r_rsp_valid;
  logic [7:0]          r_rsp_rdata;
  logic                r_rsp_err;

  logic                w_accept;
  logic                w_capture;
  logic                w_abort;
  logic                w_timeout;
  logic                w_write_sel;
  logic                w_io_sel;
  logic [ADDR_W-1:0]   w_addr_sel;
  logic [7:0]          w_wdata_sel;
  logic [11:0]         w_a_hi_sel;

  logic                w_ready_nxt;
  logic                w_ale_nxt;
  logic                w_rd_nxt;
  logic                w_wr_nxt;
  logic                w_iom_nxt;
  logic [11:0]         w_a_hi_nxt;
  logic [7:0]          w_ad_out_nxt;
  logic                w_ad_oe_nxt;
  logic                w_rsp_valid_nxt;

  assign w_accept    = (r_state == S_TI) && r_req_ready && req_valid;

  // Outputs are registered from the next state, so the request fields are
  // taken straight from the port on the accept edge.
  assign w_write_sel = w_accept ? req_write : r_write;
  assign w_io_sel    = w_accept ? req_io    : r_io;
  assign w_addr_sel  = w_accept ? req_addr  : r_addr;
  assign w_wdata_sel = w_accept ? req_wdata : r_wdata;
  assign w_a_hi_sel  = w_io_sel ? {4'h0, w_addr_sel[15:8]} : w_addr_sel[19:8];

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_wait_cnt;

  // Counts completed wait states; zero when the first TW begins.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_wait_cnt <= '0;
    end else if (r_state == S_T3) begin
      r_wait_cnt <= '0;
    end else if (r_state == S_TW && w_state_nxt == S_TW) begin
      r_wait_cnt <= r_wait_cnt + CNT_W'(1);
    end
  end

  assign w_timeout = (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_capture       = 1'b0;
    w_abort         = 1'b0;
    w_ready_nxt     = 1'b0;
    w_ale_nxt       = 1'b0;
    w_rd_nxt        = 1'b1;
    w_wr_nxt        = 1'b1;
    w_iom_nxt       = 1'b0;
    w_a_hi_nxt      = '0;
    w_ad_out_nxt    = '0;
    w_ad_oe_nxt     = 1'b0;
    w_rsp_valid_nxt = 1'b0;

    case (r_state)
      S_TI: if (w_accept) w_state_nxt = S_T1;
      S_T1: w_state_nxt = S_T2;
      S_T2: w_state_nxt = S_T3;
      S_T3, S_TW: begin
        if (READY) begin
          w_state_nxt = S_T4;
          w_capture   = ~r_write;
        end else if (r_state == S_TW && w_timeout) begin
          w_state_nxt = S_T4;
          w_abort     = 1'b1;
        end else begin
          w_state_nxt = S_TW;
        end
      end
      S_T4:    w_state_nxt = S_TI;
      default: w_state_nxt = S_TI;
    endcase

    // Bus pins for the cycle about to start.
    case (w_state_nxt)
      S_TI: w_ready_nxt = 1'b1;
      S_T1: begin
        w_ale_nxt    = 1'b1;
        w_ad_oe_nxt  = 1'b1;
        w_ad_out_nxt = w_addr_sel[7:0];
        w_iom_nxt    = w_io_sel;
        w_a_hi_nxt   = w_a_hi_sel;
      end
      S_T2, S_T3, S_TW: begin
        w_iom_nxt  = w_io_sel;
        w_a_hi_nxt = w_a_hi_sel;
        if (w_write_sel) begin
          w_wr_nxt     = 1'b0;
          w_ad_oe_nxt  = 1'b1;
          w_ad_out_nxt = w_wdata_sel;
        end else begin
          w_rd_nxt = 1'b0;
        end
      end
      S_T4: begin
        w_iom_nxt       = w_io_sel;
        w_a_hi_nxt      = w_a_hi_sel;
        w_rsp_valid_nxt = 1'b1;
        if (w_write_sel) begin
          w_ad_oe_nxt  = 1'b1;
          w_ad_out_nxt = w_wdata_sel;
        end
      end
      default: w_ready_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state     <= S_TI;
      r_write     <= 1'b0;
      r_io        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_req_ready <= 1'b0;
      r_ale       <= 1'b0;
      r_rd        <= 1'b1;
      r_wr        <= 1'b1;
      r_iom       <= 1'b0;
      r_a_hi      <= '0;
      r_ad_out    <= '0;
      r_ad_oe     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_write     <= w_write_sel;
      r_io        <= w_io_sel;
      r_addr      <= w_addr_sel;
      r_wdata     <= w_wdata_sel;
      r_req_ready <= w_ready_nxt;
      r_ale       <= w_ale_nxt;
      r_rd        <= w_rd_nxt;
      r_wr        <= w_wr_nxt;
      r_iom       <= w_iom_nxt;
      r_a_hi      <= w_a_hi_nxt;
      r_ad_out    <= w_ad_out_nxt;
      r_ad_oe     <= w_ad_oe_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_err   <= w_abort;
      if (w_capture) begin
        r_rsp_rdata <= AD_in;
      end else if (w_abort) begin
        r_rsp_rdata <= 8'hFF;
      end
    end
  end

  assign req_ready = r_req_ready;
  assign ALE       = r_ale;
  assign RD        = r_rd;
  assign WR        = r_wr;
  assign IOM       = r_iom;
  assign A_hi      = r_a_hi;
  assign AD_out    = r_ad_out;
  assign AD_oe     = r_ad_oe;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_i8088_bus_master.sv
// Bench for i8088_bus_master: per-cycle bus timing checked against a phase-count model
// with a slave that latches writes from the bus and serves reads.
module tb_i8088_bus_master;

  localparam int unsigned TO = 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_io;
  logic [19:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        ALE, RD, WR, IOM, AD_oe, READY;
  logic [11:0] A_hi;
  logic [7:0]  AD_out, AD_in;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] ref_mem    [int];
  logic [7:0] periph_mem [int];

  always #5 CLK = ~CLK;

  i8088_bus_master #(
    .ADDR_W(20)
`ifdef BUS_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TO)
`endif
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_io(req_io),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ALE(ALE), .RD(RD), .WR(WR), .IOM(IOM), .A_hi(A_hi),
    .AD_out(AD_out), .AD_oe(AD_oe), .AD_in(AD_in), .READY(READY)
  );

  function automatic logic [7:0] init_byte(input logic [19:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // One bus transaction: cycle k (1-based after accept) of L = 4 + waits cycles.
  task automatic run_txn(input bit w, input bit io, input logic [19:0] a, input logic [7:0] wd,
                         input int waits, input bit stuck);
    int          L;
    logic [7:0]  slave_d, exp_d, exp_ad;
    logic [11:0] exp_ahi;
    logic [16:0] exp_bus, got_bus;
    bit          rd_low, wr_low, exp_oe;
    L = stuck ? 4 + int'(TO) : 4 + waits;
    if (io) slave_d = 8'($urandom);
    else    slave_d = periph_mem.exists(int'(a)) ? periph_mem[int'(a)] : init_byte(a);
    if (stuck)   exp_d = 8'hFF;
    else if (io) exp_d = slave_d;
    else         exp_d = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_byte(a);
    exp_ahi = io ? {4'h0, a[15:8]} : a[19:8];

    @(negedge CLK);
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL idle_req_ready got=%b exp=1", req_ready);
    end
    req_valid = 1'b1; req_write = w; req_io = io; req_addr = a; req_wdata = wd; READY = 1'b1;
    @(posedge CLK); #1;
    req_valid = 1'b0; req_addr = 20'($urandom); req_wdata = 8'($urandom);

    for (int k = 1; k <= L; k++) begin
      READY = stuck ? (k < 3) : (k < 3 || k >= 3 + waits);
      AD_in = (READY && k >= 3) ? slave_d : (slave_d ^ 8'h81);
      @(negedge CLK);
      rd_low  = !w && k >= 2 && k <= L - 1;
      wr_low  =  w && k >= 2 && k <= L - 1;
      exp_oe  = (k == 1) || w;
      exp_ad  = (k == 1) ? a[7:0] : wd;
      exp_bus = {k == 1, !rd_low, !wr_low, io, exp_ahi, exp_oe};
      got_bus = {ALE, RD, WR, IOM, A_hi, AD_oe};
      n_checks++;
      if (got_bus !== exp_bus) begin
        n_errors++;
        $display("FAIL bus_pins k=%0d {ALE,RD,WR,IOM,A_hi,AD_oe} got=%h exp=%h", k, got_bus, exp_bus);
      end
      if (exp_oe) begin
        n_checks++;
        if (AD_out !== exp_ad) begin
          n_errors++;
          $display("FAIL ad_out k=%0d got=%h exp=%h", k, AD_out, exp_ad);
        end
      end
      n_checks++;
      if ({req_ready, rsp_valid, rsp_err} !== {1'b0, k == L, k == L && stuck}) begin
        n_errors++;
        $display("FAIL handshake k=%0d {req_ready,rsp_valid,rsp_err} got=%b exp=%b",
                 k, {req_ready, rsp_valid, rsp_err}, {1'b0, k == L, k == L && stuck});
      end
      if (w && !io && k == 3 && !WR) periph_mem[int'(a)] = AD_out;
      if (!w && k == L) begin
        n_checks++;
        if (rsp_rdata !== exp_d) begin
          n_errors++;
          $display("FAIL rsp_rdata addr=%h got=%h exp=%h", a, rsp_rdata, exp_d);
        end
      end
      if (k < L) begin
        @(posedge CLK); #1;
      end
    end
    READY = 1'b1;
    if (w && !io) ref_mem[int'(a)] = wd;
  endtask

  task automatic check_reset_pins(input string tag);
    logic [35:0] got, exp;
    got = {req_ready, ALE, RD, WR, IOM, A_hi, AD_out, AD_oe, rsp_valid, rsp_rdata, rsp_err};
    exp = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s reset_values got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_io = 1'b0;
    req_addr = '0; req_wdata = '0; AD_in = '0; READY = 1'b1;
    repeat (2) @(negedge CLK);
    check_reset_pins("por");
    RESET = 1'b0;
  endtask

  task automatic test_mem_read();
    periph_mem[int'(20'h12345)] = 8'hA5;
    ref_mem[int'(20'h12345)]    = 8'hA5;
    run_txn(1'b0, 1'b0, 20'h12345, 8'h00, 0, 1'b0);
  endtask

  task automatic test_mem_write();
    run_txn(1'b1, 1'b0, 20'h7FFFF, 8'h3C, 0, 1'b0);
    run_txn(1'b0, 1'b0, 20'h7FFFF, 8'h00, 0, 1'b0);
  endtask

  task automatic test_io_read();
    run_txn(1'b0, 1'b1, 20'hF00FF, 8'h00, 0, 1'b0);
  endtask

  task automatic test_wait_states();
    run_txn(1'b0, 1'b0, 20'h12345, 8'h00, 3, 1'b0);
    run_txn(1'b1, 1'b0, 20'h0ABCD, 8'h96, 2, 1'b0);
  endtask

  task automatic test_reset_mid();
    @(negedge CLK);
    req_valid = 1'b1; req_write = 1'b1; req_io = 1'b0; req_addr = 20'h00321; req_wdata = 8'hE7;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b1;
    #1;
    check_reset_pins("mid_t2");
    @(negedge CLK);
    RESET = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      n_checks++;
      if (rsp_valid !== 1'b0 || WR !== 1'b1) begin
        n_errors++;
        $display("FAIL post_reset_quiet i=%0d rsp_valid=%b WR=%b exp 0/1", i, rsp_valid, WR);
      end
    end
    run_txn(1'b0, 1'b0, 20'h00321, 8'h00, 1, 1'b0);
  endtask

  task automatic test_random();
    logic [19:0] pool [8];
    for (int i = 0; i < 8; i++) pool[i] = 20'($urandom);
    for (int t = 0; t < 40; t++) begin
      run_txn(1'($urandom), ($urandom_range(0, 3) == 0), pool[$urandom_range(0, 7)],
              8'($urandom), $urandom_range(0, 4), 1'b0);
    end
  endtask

`ifdef BUS_TIMEOUT_EN
  task automatic test_timeout();
    run_txn(1'b0, 1'b0, 20'h04444, 8'h00, 0, 1'b1);
    run_txn(1'b0, 1'b0, 20'h12345, 8'h00, 0, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_mem_read();
    test_mem_write();
    test_io_read();
    test_wait_states();
    test_reset_mid();
    test_random();
`ifdef BUS_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
